// File: rtl/disp_scan_decoder.sv
// Rebuilds 4-digit frames from a scanned, multiplexed 12-bit display bus and classifies them.
// Define SCAN_WATCHDOG_EN to build the scan-stall watchdog; otherwise stalled is tied low.
module disp_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] disp,
    output logic [31:0] frame,
    output logic        frame_valid,
    output logic [2:0]  symbol,
    output logic        idle,
    output logic        seq_err,
    output logic        stalled
);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        COLLECT,
        FRAME_DONE
    } state_t;

    localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES);

    logic [11:0] sync1_q, sync2_q;
    logic [11:0] cand_q, cand_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        accept;

    logic [7:0]  acc_seg;
    logic [3:0]  acc_an;
    logic [1:0]  acc_idx;
    logic        is_digit, is_idle, is_blank;

    state_t      state_q, state_d;
    logic [1:0]  exp_q, exp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] frame_q, frame_d;
    logic        frame_valid_q, frame_valid_d;
    logic [2:0]  symbol_q, symbol_d;
    logic        idle_q, idle_d;
    logic        seq_err_q, seq_err_d;
    logic        wd_force;

    function automatic logic [2:0] classify(input logic [31:0] f);
        case (f)
            32'hFFFF_FFFF: classify = 3'd0;
            32'hFFED_EDFF: classify = 3'd1;
            32'hFFDD_F9FF: classify = 3'd2;
            32'hE5FF_FFFF: classify = 3'd3;
            32'hFFFF_FF4D: classify = 3'd4;
            32'hFFFF_FFCD: classify = 3'd5;
            32'h65FF_FFFF: classify = 3'd6;
            default:       classify = 3'd7;
        endcase
    endfunction

    // Run-length filter: a value is accepted once, on the cycle its run reaches STABLE_CYCLES.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = 8'd1;
        end else if (cnt_q != CNT_ACC) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign accept  = (sync2_q == cand_q) && (cnt_q == CNT_ACC - 8'd1);
    assign acc_seg = cand_q[11:4];
    assign acc_an  = cand_q[3:0];

    always_comb begin
        is_digit = 1'b1;
        acc_idx  = 2'd0;
        case (acc_an)
            4'b0111: acc_idx = 2'd3;
            4'b1011: acc_idx = 2'd2;
            4'b1101: acc_idx = 2'd1;
            4'b1110: acc_idx = 2'd0;
            default: is_digit = 1'b0;
        endcase
    end

    assign is_idle  = (acc_an == 4'b0000) && (acc_seg == 8'hFF);
    assign is_blank = (acc_an == 4'b1111);

    // In COLLECT the current digit is always one above the expected one (mod 4).
    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        symbol_d      = symbol_q;
        idle_d        = idle_q;
        seq_err_d     = 1'b0;

        if (state_q == FRAME_DONE) begin
            frame_d       = shadow_q;
            frame_valid_d = 1'b1;
            symbol_d      = classify(shadow_q);
            state_d       = COLLECT;
            exp_d         = 2'd3;
        end else if (accept) begin
            if (is_idle) begin
                idle_d   = 1'b1;
                state_d  = WAIT_SYNC;
                shadow_d = '1;
            end else begin
                idle_d = 1'b0;
                if (!is_blank) begin
                    if (!is_digit) begin
                        seq_err_d = 1'b1;
                        state_d   = WAIT_SYNC;
                        shadow_d  = '1;
                    end else if (state_q == WAIT_SYNC) begin
                        if (acc_idx == 2'd3) begin
                            shadow_d = {acc_seg, 24'hFF_FFFF};
                            state_d  = COLLECT;
                            exp_d    = 2'd2;
                        end
                    end else if (acc_idx == exp_q) begin
                        shadow_d[{acc_idx, 3'b000} +: 8] = acc_seg;
                        if (acc_idx == 2'd0) begin
                            state_d = FRAME_DONE;
                        end else begin
                            exp_d = exp_q - 2'd1;
                        end
                    end else if (acc_idx == exp_q + 2'd1) begin
                        shadow_d[{acc_idx, 3'b000} +: 8] = acc_seg;
                    end else begin
                        seq_err_d = 1'b1;
                        if (acc_idx == 2'd3) begin
                            shadow_d = {acc_seg, 24'hFF_FFFF};
                            state_d  = COLLECT;
                            exp_d    = 2'd2;
                        end else begin
                            state_d  = WAIT_SYNC;
                            shadow_d = '1;
                        end
                    end
                end
            end
        end

        if (wd_force) begin
            state_d = WAIT_SYNC;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            cand_q        <= '1;
            cnt_q         <= '0;
            state_q       <= WAIT_SYNC;
            exp_q         <= '0;
            shadow_q      <= '1;
            frame_q       <= '1;
            frame_valid_q <= 1'b0;
            symbol_q      <= '0;
            idle_q        <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            sync1_q       <= disp;
            sync2_q       <= sync1_q;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            exp_q         <= exp_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            symbol_q      <= symbol_d;
            idle_q        <= idle_d;
            seq_err_q     <= seq_err_d;
        end
    end

`ifdef SCAN_WATCHDOG_EN
    localparam logic [18:0] WD_MAX = 19'(TIMEOUT_CYCLES);

    logic [18:0] wd_q, wd_d;
    logic [3:0]  held_q, held_d;
    logic        stalled_q, stalled_d;
    logic        an_change;

    always_comb begin
        held_d    = accept ? acc_an : held_q;
        an_change = accept && (acc_an != held_q);
        if (an_change) begin
            wd_d = '0;
        end else if (wd_q == WD_MAX) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + 19'd1;
        end
        stalled_d = (wd_d == WD_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q      <= '0;
            held_q    <= '1;
            stalled_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            held_q    <= held_d;
            stalled_q <= stalled_d;
        end
    end

    assign wd_force = stalled_d;
    assign stalled  = stalled_q;
`else
    assign wd_force = 1'b0;
    // Always 0; the timeout parameter is still referenced so both builds share one interface.
    assign stalled  = (TIMEOUT_CYCLES < 0);
`endif

    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign symbol      = symbol_q;
    assign idle        = idle_q;
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_disp_scan_decoder.sv
// Bench for disp_scan_decoder: digit-level reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_disp_scan_decoder;

    localparam int STABLE = 4;
    localparam int TMO    = 64;
    localparam int HLEN   = STABLE + 3;

    localparam logic [31:0] SYM_TBL [7] = '{
        32'hFFFF_FFFF, 32'hFFED_EDFF, 32'hFFDD_F9FF, 32'hE5FF_FFFF,
        32'hFFFF_FF4D, 32'hFFFF_FFCD, 32'h65FF_FFFF
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] disp;
    logic [31:0] frame;
    logic        frame_valid;
    logic [2:0]  symbol;
    logic        idle;
    logic        seq_err;
    logic        stalled;

    always #10 clk = ~clk;

    disp_scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .disp       (disp),
        .frame      (frame),
        .frame_valid(frame_valid),
        .symbol     (symbol),
        .idle       (idle),
        .seq_err    (seq_err),
        .stalled    (stalled)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [2:0] sym_of(input logic [31:0] f);
        for (int i = 0; i < 7; i++) begin
            if (f == SYM_TBL[i]) return 3'(i);
        end
        return 3'd7;
    endfunction

    // Reference model: raw input history -> accepted patterns -> digit progress -> frames.
    logic [12:0] hist [$];
    int          m_pos;
    logic [7:0]  m_dig [4];
    logic [31:0] m_frame;
    logic        m_fv, m_pend, m_idle, m_se, m_stall, m_ok = 1'b0;
    logic [2:0]  m_sym;
    int          m_wd;
    logic [3:0]  m_held;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist = {};
            repeat (HLEN) hist.push_back(13'h1000);
            m_pos = -1;
            for (int i = 0; i < 4; i++) m_dig[i] = 8'hFF;
            m_frame = 32'hFFFF_FFFF;
            m_fv = 1'b0; m_pend = 1'b0; m_sym = 3'd0;
            m_idle = 1'b0; m_se = 1'b0; m_stall = 1'b0;
            m_wd = 0; m_held = 4'hF; m_ok = 1'b1;
        end else begin
            logic [12:0] v;
            logic [7:0]  seg;
            logic [3:0]  an;
            bit          acc;
            int          idx, nxt, lst;
            hist.push_back({1'b0, disp});
            if (hist.size() > HLEN) void'(hist.pop_front());
            // the sample from two edges ago must close a run of exactly STABLE equal samples
            v   = hist[HLEN-3];
            acc = (hist[0] != v);
            for (int j = 1; j <= STABLE - 1; j++) if (hist[HLEN-3-j] != v) acc = 0;
            seg = v[11:4];
            an  = v[3:0];
            m_fv = 1'b0;
            m_se = 1'b0;
            if (m_pend) begin
                m_frame = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
                m_sym   = sym_of(m_frame);
                m_fv    = 1'b1;
                m_pend  = 1'b0;
            end else if (acc) begin
                case (an)
                    4'b0111: idx = 3;
                    4'b1011: idx = 2;
                    4'b1101: idx = 1;
                    4'b1110: idx = 0;
                    default: idx = -1;
                endcase
                if (an == 4'b0000 && seg == 8'hFF) begin
                    m_idle = 1'b1;
                    m_pos  = -1;
                end else begin
                    m_idle = 1'b0;
                    if (an == 4'b1111) begin
                        // blank: ignored
                    end else if (idx < 0) begin
                        m_se  = 1'b1;
                        m_pos = -1;
                    end else if (m_pos < 0) begin
                        if (idx == 3) begin m_dig[3] = seg; m_pos = 1; end
                    end else begin
                        nxt = (m_pos == 4) ? 3 : 3 - m_pos;
                        lst = 4 - m_pos;
                        if (idx == nxt) begin
                            m_dig[idx] = seg;
                            m_pos = (m_pos == 4) ? 1 : m_pos + 1;
                            if (m_pos == 4) m_pend = 1'b1;
                        end else if (idx == lst) begin
                            m_dig[idx] = seg;
                        end else begin
                            m_se = 1'b1;
                            if (idx == 3) begin m_dig[3] = seg; m_pos = 1; end
                            else m_pos = -1;
                        end
                    end
                end
            end
`ifdef SCAN_WATCHDOG_EN
            if (acc && an != m_held) m_wd = 0;
            else if (m_wd < TMO) m_wd++;
            if (acc) m_held = an;
            m_stall = (m_wd == TMO);
            if (m_stall) m_pos = -1;
`endif
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("frame", frame, m_frame);
            check("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
            check("symbol", {29'd0, symbol}, {29'd0, m_sym});
            check("idle", {31'd0, idle}, {31'd0, m_idle});
            check("seq_err", {31'd0, seq_err}, {31'd0, m_se});
            check("stalled", {31'd0, stalled}, {31'd0, m_stall});
        end
    end

    int fv_cnt = 0;
    int se_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (frame_valid) fv_cnt++;
            if (seq_err) se_cnt++;
        end
    end

    task automatic drive(input logic [7:0] seg, input logic [3:0] an, input int n);
        disp = {seg, an};
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [31:0] f, input int dwell);
        drive(f[31:24], 4'b0111, dwell);
        drive(f[23:16], 4'b1011, dwell);
        drive(f[15:8],  4'b1101, dwell);
        drive(f[7:0],   4'b1110, dwell);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n, fv0, se0;
        reset = 1'b1;
        disp  = 12'hFFF;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_frame", frame, 32'hFFFF_FFFF);
        check("rst_symbol", {29'd0, symbol}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd0);
        check("rst_stalled", {31'd0, stalled}, 32'd0);

        // equal frame plus d0-to-frame_valid latency
        se0 = se_cnt;
        drive(8'hFF, 4'b0111, 16);
        drive(8'hED, 4'b1011, 16);
        drive(8'hED, 4'b1101, 16);
        disp = {8'hFF, 4'b1110};
        n = 0;
        while (frame_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 32'd7);
        check("eq_frame", frame, 32'hFFED_EDFF);
        check("eq_symbol", {29'd0, symbol}, 32'd1);
        drive(8'hFF, 4'b1110, 9);
        check("eq_no_seqerr", se_cnt - se0, 32'd0);

        // two not-equal frames then less-than
        fv0 = fv_cnt;
        scan(32'hFFDD_F9FF, 16);
        scan(32'hFFDD_F9FF, 16);
        check("ne_fv_count", fv_cnt - fv0, 32'd2);
        check("ne_symbol", {29'd0, symbol}, 32'd2);
        scan(32'hE5FF_FFFF, 16);
        check("lt_fv_count", fv_cnt - fv0, 32'd3);
        check("lt_symbol", {29'd0, symbol}, 32'd3);

        // 2-cycle anode glitch during the d3 dwell
        se0 = se_cnt; fv0 = fv_cnt;
        drive(8'hFF, 4'b0111, 6);
        drive(8'hFF, 4'b1011, 2);
        drive(8'hFF, 4'b0111, 8);
        drive(8'hFF, 4'b1011, 16);
        drive(8'hFF, 4'b1101, 16);
        drive(8'h4D, 4'b1110, 16);
        check("glitch_seqerr", se_cnt - se0, 32'd0);
        check("glitch_fv", fv_cnt - fv0, 32'd1);
        check("glitch_frame", frame, 32'hFFFF_FF4D);
        check("ge_symbol", {29'd0, symbol}, 32'd4);

        // skipped digit
        se0 = se_cnt; fv0 = fv_cnt;
        drive(8'hFF, 4'b0111, 16);
        drive(8'hFF, 4'b1101, 16);
        drive(8'hFF, 4'b1110, 16);
        check("skip_seqerr", se_cnt - se0, 32'd1);
        check("skip_no_fv", fv_cnt - fv0, 32'd0);
        scan(32'hFFFF_FFCD, 16);
        check("skip_recover_fv", fv_cnt - fv0, 32'd1);
        check("gt_frame", frame, 32'hFFFF_FFCD);
        check("gt_symbol", {29'd0, symbol}, 32'd5);

        // idle mid-frame
        se0 = se_cnt;
        drive(8'hFF, 4'b0111, 16);
        drive(8'hFF, 4'b1011, 16);
        drive(8'hFF, 4'b0000, 10);
        check("idle_set", {31'd0, idle}, 32'd1);
        check("idle_frame_hold", frame, 32'hFFFF_FFCD);
        check("idle_no_seqerr", se_cnt - se0, 32'd0);
        scan(32'h65FF_FFFF, 16);
        check("idle_clear", {31'd0, idle}, 32'd0);
        check("le_symbol", {29'd0, symbol}, 32'd6);

        // frozen bus
        disp = {8'hFF, 4'b0111};
`ifdef SCAN_WATCHDOG_EN
        n = 0;
        while (stalled !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wd_latency", n, 32'(2 + STABLE + TMO));
`else
        repeat (100) @(negedge clk);
        check("wd_absent", {31'd0, stalled}, 32'd0);
`endif
        drive(8'hFF, 4'b1011, 8);
        check("wd_clear", {31'd0, stalled}, 32'd0);

        // reset after d3 and d2 captured
        drive(8'hFF, 4'b0000, 10);
        drive(8'h11, 4'b0111, 16);
        drive(8'h22, 4'b1011, 16);
        disp = {8'h33, 4'b1101};
        @(negedge clk);
        #3;
        reset = 1'b1;
        disp  = 12'hFFF;
        #1;
        check("arst_frame", frame, 32'hFFFF_FFFF);
        check("arst_symbol", {29'd0, symbol}, 32'd0);
        check("arst_fv", {31'd0, frame_valid}, 32'd0);
        check("arst_idle", {31'd0, idle}, 32'd0);
        check("arst_seqerr", {31'd0, seq_err}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fv0 = fv_cnt;
        drive(8'h33, 4'b1101, 16);
        drive(8'h44, 4'b1110, 16);
        check("arst_no_partial", fv_cnt - fv0, 32'd0);
        scan(32'hFFED_EDFF, 16);
        check("arst_recover_fv", fv_cnt - fv0, 32'd1);
        check("arst_recover_sym", {29'd0, symbol}, 32'd1);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scan_decoder.md
Name: disp_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed 4-digit display drivers: samples the 12-bit scanned display bus and rebuilds the four digit segment codes into one frame.
- Classifies each complete frame into a comparator symbol code.
- Used as an on-chip loopback monitor and bench checker for display-driver blocks. It sits on the same clk as the driver.

Parameters:
STABLE_CYCLES, 4, number of consecutive identical bus samples required before a sample is accepted (glitch/ghost filter); range 2..255
TIMEOUT_CYCLES, 262144, number of cycles allowed without an accepted anode change before the stall flag is raised (2 × the 131072-cycle digit dwell)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
disp  in  12  scanned bus; disp[11:4] = segments, active-low; disp[3:0] = anodes, active-low
frame  out  32  last complete frame {d3,d2,d1,d0}; d3 is captured with anodes 0111 and d0 with anodes 1110
frame_valid  out  1  one-cycle pulse when frame updates
symbol  out  3  classification of frame
idle  out  1  high while the bus shows anodes 0000 with segments FF
seq_err  out  1  one-cycle pulse on an out-of-order or multi-hot anode pattern
stalled  out  1  high while the watchdog has expired

Behaviour:
- Reset values: frame = 32'hFFFF_FFFF, symbol = 0, frame_valid = 0, seq_err = 0, idle = 0, stalled = 0, FSM = WAIT_SYNC, all counters = 0.
- Input stage: disp is registered twice (synchroniser). A filter counter counts consecutive equal samples. Value S is accepted when the count reaches STABLE_CYCLES. Each change restarts the count at 1. Every accepted value is held until a different stable value is accepted.
- Anode index map: 0111→3, 1011→2, 1101→1, 1110→0. 0000 = idle. 1111 = blank and is ignored. Any other pattern is multi-hot.
- FSM states:
  - WAIT_SYNC: on accepted index 3, capture d3 and go to COLLECT with expected index 2.
  - COLLECT: on accepted index equal to expected, capture the segments and decrement expected. On accepting index 0, capture d0 and go to FRAME_DONE. Re-acceptance of the current index during dwell is harmless: capture is overwritten with the same digit.
  - FRAME_DONE: for one cycle, frame <= shadow, frame_valid = 1, symbol updated. Next state is COLLECT with expected index 3.
  - In COLLECT, expected index 3 means the next accepted index 3 starts the next frame.
- Errors:
  - Accepted index that is neither current nor expected: seq_err pulse, shadow discarded, go to WAIT_SYNC. If the offending index is 3, it also captures d3 and enters COLLECT the same cycle.
  - Multi-hot pattern: seq_err pulse, go to WAIT_SYNC.
- Idle: accepted 0000 sets idle = 1, discards the shadow and forces WAIT_SYNC. The frame output is retained. idle clears on the next accepted non-0000 pattern.
- Latency: a frame_valid pulse occurs exactly 2 + STABLE_CYCLES + 1 cycles after the d0 pattern first appears, provided it stays stable.
- Symbol table (compare full frame, hex d3 d2 d1 d0):
  - FF FF FF FF = 0 (blank)
  - FF ED ED FF = 1 (=)
  - FF DD F9 FF = 2 (≠)
  - E5 FF FF FF = 3 (<)
  - FF FF FF 4D = 4 (≥)
  - FF FF FF CD = 5 (>)
  - 65 FF FF FF = 6 (≤)
  - anything else = 7 (unknown)
- Simultaneous events: reset dominates everything. Idle dominates seq_err; if both apply, no seq_err pulse. A FRAME_DONE cycle is never skipped.
- Reset mid-frame discards the partial shadow.

Optional Feature:
- SCAN_WATCHDOG_EN defined:
  - A 19-bit watchdog counts cycles since the last accepted anode change.
  - At TIMEOUT_CYCLES it sets stalled = 1, saturates, and forces WAIT_SYNC.
  - stalled clears on the next accepted change.
- Not defined: no watchdog logic is generated; stalled is tied to 0.

Test Plan:
- Scan = frame (FF,ED,ED,FF) with dwell 16 cycles, STABLE_CYCLES = 4 → after d0, frame_valid pulses; frame = 32'hFFEDEDFF; symbol = 1; seq_err never asserts.
- Two consecutive ≠ frames (FF,DD,F9,FF), then switch to < (E5,FF,FF,FF) → two frame_valid pulses with symbol = 2, then symbol = 3 on the next complete frame. No partial-frame output occurs.
- Inject 2-cycle glitches (anodes 1011 during a 0111 dwell) → glitch rejected; no seq_err; frame still completes correctly.
- Anode order 0111 → 1101 (index 2 skipped) → one seq_err pulse; no frame_valid until the next clean 0111..1110 sequence; then frame_valid with the correct frame.
- Bus = {FF,0000} held 10 cycles mid-frame → idle = 1, frame holds its previous value; a later full ≤ scan gives idle = 0 and symbol = 6.
- With SCAN_WATCHDOG_EN and TIMEOUT_CYCLES = 64, bus frozen at 0111 → stalled = 1 at cycle 64 after acceptance; the next change clears it. Without the macro, stalled stays 0.
- Assert reset during COLLECT after d3 and d2 are captured → all outputs return to reset values immediately; no frame_valid is produced from the partial data.
